uart_tx_sequencer: RTL and testbench

//  Word-level front end for the byte UART transmitter. Buffers 16-bit words from the

---
 rtl/uart_tx_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer
//   Word-level front end for a byte UART transmitter. 16-bit words (or single bytes when
//   byte_mode is set) are buffered in a small FIFO and sent one byte at a time, low byte
//   first, through the transmitter's begin/active/over handshake. Runs on s_tick, the
//   transmitter's own 16x baud tick, so all handshakes are synchronous.
// Ports
//   s_tick, rst          clock (rising edge) and asynchronous active-high reset
//   wr_en, wr_data,      write strobe, word and per-word byte_mode flag
//   byte_mode
//   full, empty, busy    FIFO status; busy also covers a frame in flight
//   overflow             sticky: write attempted while full
//   timeout_err          sticky: transmitter never raised transmit_active
//   tx_data,             byte to the transmitter ({8'h00, byte}) and one-tick launch pulse
//   transmit_begin
//   transmit_active,     transmitter status: busy with a frame / end-of-frame pulse
//   transmit_over
module uart_tx_sequencer #(
   parameter int unsigned DEPTH_LOG2   = 2,
   parameter int unsigned SETTLE_TICKS = 32,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic        s_tick,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [15:0] wr_data,
   input  logic        byte_mode,
   output logic        full,
   output logic        empty,
   output logic        busy,
   output logic        overflow,
   output logic        timeout_err,
   output logic [15:0] tx_data,
   output logic        transmit_begin,
   input  logic        transmit_active,
   input  logic        transmit_over
);

   localparam int unsigned Depth = 2 ** DEPTH_LOG2;
   localparam int unsigned PtrW  = DEPTH_LOG2 + 1;
   localparam int unsigned SetW  = $clog2(SETTLE_TICKS + 1);
   localparam int unsigned TimW  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {StSettle, StIdle, StLaunch, StWaitAct, StWaitOver} state_e;

   state_e            state_q, state_d;
   logic [16:0]       mem_q [Depth];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic              full_q, full_d, empty_q, empty_d, busy_q, busy_d;
   logic              overflow_q, overflow_d, timeout_err_q, timeout_err_d;
   logic [15:0]       tx_data_q, tx_data_d, hold_q, hold_d;
   logic              hold_bm_q, hold_bm_d, lo_sel_q, lo_sel_d;
   logic              begin_q, begin_d;
   logic [SetW-1:0]   settle_q, settle_d;
   logic [TimW-1:0]   timer_q, timer_d;
   logic              push, pop;

   assign push = wr_en && !full_q;

   // FIFO storage: no reset needed, validity is tracked by the pointers.
   always_ff @(posedge s_tick) begin
      if (push) begin
         mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {byte_mode, wr_data};
      end
   end

   always_comb begin
      state_d       = state_q;
      settle_d      = settle_q;
      timer_d       = timer_q;
      hold_d        = hold_q;
      hold_bm_d     = hold_bm_q;
      lo_sel_d      = lo_sel_q;
      tx_data_d     = tx_data_q;
      begin_d       = 1'b0;
      timeout_err_d = timeout_err_q;
      pop           = 1'b0;
      unique case (state_q)
         StSettle: begin
            // Wait for a reset-less transmitter to finish any frame it was sending.
            if (transmit_active) begin
               settle_d = '0;
            end else if (settle_q == SetW'(SETTLE_TICKS - 1)) begin
               settle_d = '0;
               state_d  = StIdle;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         StIdle: begin
            if (!empty_q) begin
               pop                 = 1'b1;
               {hold_bm_d, hold_d} = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
               lo_sel_d            = 1'b1;
               state_d             = StLaunch;
            end
         end
         StLaunch: begin
            tx_data_d = {8'h00, lo_sel_q ? hold_q[7:0] : hold_q[15:8]};
            begin_d   = 1'b1;
            timer_d   = '0;
            state_d   = StWaitAct;
         end
         StWaitAct: begin
            if (transmit_active) begin
               state_d = StWaitOver;
            end else if (timer_q == TimW'(TIMEOUT - 1)) begin
               timeout_err_d = 1'b1;
               state_d       = StIdle;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StWaitOver: begin
            // Only reached after transmit_active was seen high, so a stale
            // transmit_over from before the launch cannot end the frame early.
            if (transmit_over) begin
               if (lo_sel_q && !hold_bm_q) begin
                  lo_sel_d = 1'b0;
                  state_d  = StLaunch;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StSettle;
      endcase
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q + PtrW'(push);
      rd_ptr_d   = rd_ptr_q + PtrW'(pop);
      empty_d    = (wr_ptr_d == rd_ptr_d);
      full_d     = (wr_ptr_d[PtrW-1] != rd_ptr_d[PtrW-1]) &&
                   (wr_ptr_d[PtrW-2:0] == rd_ptr_d[PtrW-2:0]);
      // A write while full is lost even if a pop frees a slot on the same tick.
      overflow_d = overflow_q || (wr_en && full_q);
      busy_d     = !empty_d || (state_d == StLaunch) || (state_d == StWaitAct) ||
                   (state_d == StWaitOver);
   end

   always_ff @(posedge s_tick or posedge rst) begin
      if (rst) begin
         state_q       <= StSettle;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         full_q        <= 1'b0;
         empty_q       <= 1'b1;
         busy_q        <= 1'b0;
         overflow_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         tx_data_q     <= '0;
         hold_q        <= '0;
         hold_bm_q     <= 1'b0;
         lo_sel_q      <= 1'b0;
         begin_q       <= 1'b0;
         settle_q      <= '0;
         timer_q       <= '0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         full_q        <= full_d;
         empty_q       <= empty_d;
         busy_q        <= busy_d;
         overflow_q    <= overflow_d;
         timeout_err_q <= timeout_err_d;
         tx_data_q     <= tx_data_d;
         hold_q        <= hold_d;
         hold_bm_q     <= hold_bm_d;
         lo_sel_q      <= lo_sel_d;
         begin_q       <= begin_d;
         settle_q      <= settle_d;
         timer_q       <= timer_d;
      end
   end

   assign full           = full_q;
   assign empty          = empty_q;
   assign busy           = busy_q;
   assign overflow       = overflow_q;
   assign timeout_err    = timeout_err_q;
   assign tx_data        = tx_data_q;
   assign transmit_begin = begin_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: a small transmitter model answers the handshake, the
// stimulus pushes expected bytes into a queue, and a monitor pops and compares on every
// transmit_begin pulse.
module tb_uart_tx_sequencer;

   localparam int unsigned SettleTicks = 32;
   localparam int unsigned FrameTicks  = 20;

   logic        s_tick = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic [15:0] wr_data = '0;
   logic        byte_mode = 1'b0;
   logic        full, empty, busy, overflow, timeout_err, transmit_begin;
   logic [15:0] tx_data;
   logic        transmit_active = 1'b1;
   logic        transmit_over = 1'b0;

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  exp_q[$];
   int          begin_cnt = 0;
   logic        prev_begin = 1'b0;
   bit          skip_act = 1'b0;
   time         last_begin_t = 0;

   uart_tx_sequencer #(
      .DEPTH_LOG2  (2),
      .SETTLE_TICKS(SettleTicks),
      .TIMEOUT     (255)
   ) dut (
      .s_tick         (s_tick),
      .rst            (rst),
      .wr_en          (wr_en),
      .wr_data        (wr_data),
      .byte_mode      (byte_mode),
      .full           (full),
      .empty          (empty),
      .busy           (busy),
      .overflow       (overflow),
      .timeout_err    (timeout_err),
      .tx_data        (tx_data),
      .transmit_begin (transmit_begin),
      .transmit_active(transmit_active),
      .transmit_over  (transmit_over)
   );

   always #5 s_tick = ~s_tick;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every launch must carry the next expected byte.
   always @(negedge s_tick) begin
      if (transmit_begin === 1'b1) begin
         begin_cnt++;
         last_begin_t = $time;
         check("begin_width", {31'd0, prev_begin}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_launch: got tx_data %0h expected no launch", tx_data);
         end else begin
            check("tx_byte", {16'd0, tx_data}, {24'd0, exp_q.pop_front()});
         end
      end
      prev_begin = transmit_begin;
   end

   // Transmitter model: powers up with transmit_active high, has no reset.
   initial begin
      transmit_active = 1'b1;
      repeat (8) @(negedge s_tick);
      transmit_active = 1'b0;
      forever begin
         @(negedge s_tick);
         if (transmit_begin === 1'b1) begin
            if (skip_act) begin
               skip_act = 1'b0;
            end else begin
               repeat (2) @(negedge s_tick);
               transmit_active = 1'b1;
               repeat (FrameTicks) @(negedge s_tick);
               transmit_active = 1'b0;
               repeat (2) @(negedge s_tick);
               transmit_over = 1'b1;
               @(negedge s_tick);
               transmit_over = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_full"}, {31'd0, full}, 32'd0);
      check({tag, "_empty"}, {31'd0, empty}, 32'd1);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
      check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
      check({tag, "_tx_data"}, {16'd0, tx_data}, 32'd0);
      check({tag, "_begin"}, {31'd0, transmit_begin}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge s_tick);
      wr_en = 1'b0;
      rst   = 1'b1;
      repeat (2) @(negedge s_tick);
      check_reset_values("reset");
      rst = 1'b0;
   endtask

   task automatic write(input logic [15:0] d, input logic bm);
      @(negedge s_tick);
      wr_en     = 1'b1;
      wr_data   = d;
      byte_mode = bm;
      @(negedge s_tick);
      wr_en     = 1'b0;
      byte_mode = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge s_tick);
         if (exp_q.size() == 0 && busy === 1'b0) done = 1'b1;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL %s_drain: got busy=%0b pending=%0d expected idle", name, busy,
                  exp_q.size());
      end
      repeat (3) @(negedge s_tick);
   endtask

   task automatic wait_active(input logic level, input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 500 && !seen; i++) begin
         @(posedge s_tick);
         if (transmit_active === level) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s: got no transmit_active=%0b expected it", name, level);
      end
   endtask

   initial begin
      int b0;
      int cnt;
      bit seen;
      logic [15:0] words [5];
      words[0] = 16'h0102; words[1] = 16'h0304; words[2] = 16'h0506;
      words[3] = 16'h0708; words[4] = 16'hDEAD;

      // T1: full word, low byte first, two single-tick launches.
      do_reset();
      repeat (40) @(negedge s_tick);
      b0 = begin_cnt;
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'hA5);
      write(16'hA55A, 1'b0);
      check("t1_busy_after_write", {31'd0, busy}, 32'd1);
      wait_drain("t1");
      check("t1_launches", begin_cnt - b0, 32'd2);
      check("t1_busy_end", {31'd0, busy}, 32'd0);
      check("t1_empty_end", {31'd0, empty}, 32'd1);

      // T2: byte mode sends only the low byte.
      b0 = begin_cnt;
      exp_q.push_back(8'hC3);
      write(16'h12C3, 1'b1);
      wait_drain("t2");
      check("t2_launches", begin_cnt - b0, 32'd1);

      // T6: write coincident with a pop while three words are queued.
      exp_q.push_back(8'hAB);
      b0 = begin_cnt;
      write(16'h00AB, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge s_tick);
         if (transmit_begin === 1'b1) seen = 1'b1;
      end
      check("t6_first_launch", {31'd0, seen}, 32'd1);
      for (int i = 1; i < 4; i++) begin
         exp_q.push_back(words[i][7:0]);
         exp_q.push_back(words[i][15:8]);
         write(words[i], 1'b0);
      end
      check("t6_full_at_3", {31'd0, full}, 32'd0);
      check("t6_empty_at_3", {31'd0, empty}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(posedge s_tick);
         if (transmit_over === 1'b1) seen = 1'b1;
      end
      check("t6_over_seen", {31'd0, seen}, 32'd1);
      @(negedge s_tick);
      exp_q.push_back(8'h55);
      exp_q.push_back(8'h66);
      wr_en   = 1'b1;
      wr_data = 16'h6655;
      @(negedge s_tick);
      wr_en = 1'b0;
      check("t6_full_after", {31'd0, full}, 32'd0);
      check("t6_overflow", {31'd0, overflow}, 32'd0);
      check("t6_empty_after", {31'd0, empty}, 32'd0);
      wait_drain("t6");
      check("t6_launches", begin_cnt - b0, 32'd9);

      // T3: five back-to-back writes during settle; fifth is dropped.
      do_reset();
      b0 = begin_cnt;
      @(negedge s_tick);
      for (int i = 0; i < 5; i++) begin
         wr_en   = 1'b1;
         wr_data = words[i];
         if (i < 4) begin
            exp_q.push_back(words[i][7:0]);
            exp_q.push_back(words[i][15:8]);
         end
         @(negedge s_tick);
         if (i == 2) check("t3_full_after_3", {31'd0, full}, 32'd0);
         if (i == 3) check("t3_full_after_4", {31'd0, full}, 32'd1);
         if (i == 3) check("t3_overflow_before_5", {31'd0, overflow}, 32'd0);
      end
      wr_en = 1'b0;
      check("t3_overflow", {31'd0, overflow}, 32'd1);
      wait_drain("t3");
      check("t3_launches", begin_cnt - b0, 32'd8);
      check("t3_empty_end", {31'd0, empty}, 32'd1);
      check("t3_overflow_sticky", {31'd0, overflow}, 32'd1);

      // T4: transmitter ignores the first launch; timeout then normal send.
      b0 = begin_cnt;
      skip_act = 1'b1;
      exp_q.push_back(8'h34);
      exp_q.push_back(8'h78);
      exp_q.push_back(8'h56);
      write(16'h1234, 1'b0);
      write(16'h5678, 1'b0);
      check("t4_no_err_yet", {31'd0, timeout_err}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 600 && !seen; i++) begin
         @(negedge s_tick);
         if (timeout_err === 1'b1) seen = 1'b1;
      end
      check("t4_timeout_err", {31'd0, timeout_err}, 32'd1);
      check("t4_timeout_ticks", ($time - last_begin_t) / 10, 32'd255);
      wait_drain("t4");
      check("t4_launches", begin_cnt - b0, 32'd3);

      // T5: reset mid-frame, then no launch until the old frame is quiet for settle.
      exp_q.push_back(8'hEF);
      write(16'hBEEF, 1'b0);
      wait_active(1'b1, "t5_active_high");
      repeat (5) @(negedge s_tick);
      rst = 1'b1;
      #1;
      exp_q.delete();
      check_reset_values("t5");
      @(negedge s_tick);
      rst = 1'b0;
      exp_q.push_back(8'h11);
      write(16'h0011, 1'b1);
      wait_active(1'b0, "t5_active_low");
      cnt  = 0;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge s_tick);
         cnt++;
         if (transmit_begin === 1'b1) seen = 1'b1;
      end
      check("t5_settle_gap", cnt, SettleTicks + 2);
      wait_drain("t5");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
